// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared types and elaboration-time helpers for the multi-channel serial FIR.
//   state_t      : controller states (IDLE -> ACCUM -> HOLD -> IDLE)
//   idx_w()      : index width for an n-entry table, never less than 1 bit
//   acc_w()      : accumulator width that holds NCOEFS full-precision products
//   round_const(): round-half-up constant 2^(FRAC-1) preloaded into the acc
// -----------------------------------------------------------------------------
package fir_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   function automatic int idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic int acc_w(input int width, input int ncoefs);
      return 2 * width + $clog2(ncoefs);
   endfunction

   function automatic logic [63:0] round_const(input int frac);
      return 64'd1 << (frac - 1);
   endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// -----------------------------------------------------------------------------
// fir_mac_unit
// Shared multiply-accumulator of the serial FIR plus its output stage.
// The accumulator is preloaded with the rounding constant, accumulates one
// full-precision product per enabled cycle, and the result is the accumulator
// arithmetically shifted right by FRAC, then reduced to WIDTH bits.
//
// Build option FIR_SATURATE_EN: reduce by clamping to the signed WIDTH range
// and raise a sticky o_sat_flag; otherwise reduce by two's-complement wrap.
//
// Ports:
//   clock, nreset : clock, asynchronous active-low reset (clears acc/flag)
//   i_load        : preload accumulator with the rounding constant
//   i_en          : accumulate i_coef * i_sample
//   i_hold        : result is being presented (qualifies the saturation flag)
//   i_coef        : signed coefficient, Q(FRAC)
//   i_sample      : signed sample
//   o_result      : reduced WIDTH-bit result of the current accumulator
//   o_sat_flag    : sticky clamp indicator (FIR_SATURATE_EN only)
// -----------------------------------------------------------------------------
module fir_mac_unit
   import fir_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int NCOEFS = 29,
   parameter int FRAC   = 8
) (
   input  logic                    clock,
   input  logic                    nreset,
   input  logic                    i_load,
   input  logic                    i_en,
   input  logic                    i_hold,
   input  logic signed [WIDTH-1:0] i_coef,
   input  logic signed [WIDTH-1:0] i_sample,
   output logic signed [WIDTH-1:0] o_result
`ifdef FIR_SATURATE_EN
   ,
   output logic                    o_sat_flag
`endif
);

   localparam int ACC_W  = acc_w(WIDTH, NCOEFS);
   localparam int PROD_W = 2 * WIDTH;
   localparam logic signed [ACC_W-1:0] RND = ACC_W'(round_const(FRAC));

   logic signed [ACC_W-1:0]  r_acc;
   logic signed [PROD_W-1:0] w_coef_x;
   logic signed [PROD_W-1:0] w_samp_x;
   logic signed [PROD_W-1:0] w_prod;
   logic signed [ACC_W-1:0]  w_prod_x;
   logic signed [ACC_W-1:0]  w_shift;

   // Operands widened first so the product is exact in PROD_W bits.
   assign w_coef_x = {{WIDTH{i_coef[WIDTH-1]}}, i_coef};
   assign w_samp_x = {{WIDTH{i_sample[WIDTH-1]}}, i_sample};
   assign w_prod   = w_coef_x * w_samp_x;
   assign w_prod_x = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
   assign w_shift  = r_acc >>> FRAC;

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset)
         r_acc <= '0;
      else if (i_load)
         r_acc <= RND;
      else if (i_en)
         r_acc <= r_acc + w_prod_x;
   end

`ifdef FIR_SATURATE_EN
   localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

   function automatic logic signed [WIDTH-1:0] reduce(input logic signed [ACC_W-1:0] v);
      if (v > MAXV)
         return {1'b0, {(WIDTH-1){1'b1}}};
      else if (v < MINV)
         return {1'b1, {(WIDTH-1){1'b0}}};
      else
         return v[WIDTH-1:0];
   endfunction

   logic w_clamp;
   logic r_sat_flag;

   assign w_clamp = (w_shift > MAXV) || (w_shift < MINV);

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset)
         r_sat_flag <= 1'b0;
      else if (i_hold && w_clamp)
         r_sat_flag <= 1'b1;
   end

   assign o_sat_flag = r_sat_flag;
`else
   function automatic logic signed [WIDTH-1:0] reduce(input logic signed [ACC_W-1:0] v);
      return v[WIDTH-1:0];
   endfunction
`endif

   assign o_result = reduce(w_shift);

endmodule

// File: rtl/fir_mc_serial.sv
// -----------------------------------------------------------------------------
// fir_mc_serial
// Multi-channel time-multiplexed FIR. Each accepted sample is pushed into its
// channel's circular delay line, then NCOEFS taps are accumulated one per cycle
// in the shared fir_mac_unit, and the result is held until downstream takes it.
//
// Build option FIR_SATURATE_EN: clamped output and sticky sat_flag port;
// without it the output wraps and sat_flag does not exist.
//
// Ports:
//   clock, nreset          : clock, asynchronous active-low reset
//   coef_we/addr/data      : coefficient write (only taken in IDLE, addr<NCOEFS)
//   coef_drop              : one-cycle pulse after a write was ignored
//   in_valid/ready/chan/data   : sample input handshake
//   out_valid/ready/chan/data  : result output handshake
//   busy                   : controller not in IDLE
//   sat_flag               : sticky saturation indicator (FIR_SATURATE_EN only)
// -----------------------------------------------------------------------------
module fir_mc_serial
   import fir_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int NCOEFS = 29,
   parameter int NCHAN  = 2,
   parameter int FRAC   = 8
) (
   input  logic                          clock,
   input  logic                          nreset,
   input  logic                          coef_we,
   input  logic [idx_w(NCOEFS)-1:0]      coef_addr,
   input  logic signed [WIDTH-1:0]       coef_data,
   output logic                          coef_drop,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [idx_w(NCHAN)-1:0]       in_chan,
   input  logic signed [WIDTH-1:0]       in_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [idx_w(NCHAN)-1:0]       out_chan,
   output logic signed [WIDTH-1:0]       out_data,
   output logic                          busy
`ifdef FIR_SATURATE_EN
   ,
   output logic                          sat_flag
`endif
);

   localparam int CHAN_W = idx_w(NCHAN);
   localparam int TAP_W  = idx_w(NCOEFS);
   localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NCOEFS - 1);

   state_t                  r_state;
   logic signed [WIDTH-1:0] r_coef [NCOEFS];
   logic signed [WIDTH-1:0] r_dly  [NCHAN][NCOEFS];
   logic [TAP_W-1:0]        r_head [NCHAN];
   logic [TAP_W-1:0]        r_tap;
   logic [TAP_W-1:0]        r_rdptr;
   logic [CHAN_W-1:0]       r_chan;
   logic                    r_in_ready;
   logic                    r_out_valid;
   logic                    r_busy;
   logic                    r_coef_drop;

   logic                    w_idle;
   logic                    w_chan_ok;
   logic                    w_addr_ok;
   logic                    w_coef_wr;
   logic                    w_accept;
   logic [TAP_W-1:0]        w_new_head;
   logic signed [WIDTH-1:0] w_mac_coef;
   logic signed [WIDTH-1:0] w_mac_samp;
   logic signed [WIDTH-1:0] w_result;

   function automatic logic [TAP_W-1:0] next_ptr(input logic [TAP_W-1:0] p);
      return (p == LAST_TAP) ? '0 : p + TAP_W'(1);
   endfunction

   function automatic logic [TAP_W-1:0] prev_ptr(input logic [TAP_W-1:0] p);
      return (p == '0) ? LAST_TAP : p - TAP_W'(1);
   endfunction

   assign w_idle     = (r_state == IDLE);
   assign w_chan_ok  = (int'(in_chan) < NCHAN);
   assign w_addr_ok  = (int'(coef_addr) < NCOEFS);
   assign w_coef_wr  = coef_we && w_idle && w_addr_ok;
   // A sample on a non-existent channel still completes its handshake but is
   // otherwise ignored.
   assign w_accept   = w_idle && in_valid && w_chan_ok;
   assign w_new_head = next_ptr(r_head[in_chan]);
   assign w_mac_coef = r_coef[r_tap];
   assign w_mac_samp = r_dly[r_chan][r_rdptr];

   // Coefficient RAM; a write in the accept cycle lands before tap 0 is read.
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         for (int k = 0; k < NCOEFS; k++)
            r_coef[k] <= '0;
      end else if (w_coef_wr) begin
         r_coef[coef_addr] <= coef_data;
      end
   end

   // Delay lines: the head points at the newest sample; taps walk backwards.
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         for (int c = 0; c < NCHAN; c++) begin
            r_head[c] <= '0;
            for (int k = 0; k < NCOEFS; k++)
               r_dly[c][k] <= '0;
         end
      end else if (w_accept) begin
         r_dly[in_chan][w_new_head] <= in_data;
         r_head[in_chan]            <= w_new_head;
      end
   end

   // Controller
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         r_state     <= IDLE;
         r_tap       <= '0;
         r_rdptr     <= '0;
         r_chan      <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_coef_drop <= 1'b0;
      end else begin
         r_coef_drop <= coef_we && !w_coef_wr;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_chan     <= in_chan;
                  r_tap      <= '0;
                  r_rdptr    <= w_new_head;
                  r_state    <= ACCUM;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
               end
            end
            ACCUM: begin
               r_rdptr <= prev_ptr(r_rdptr);
               if (r_tap == LAST_TAP) begin
                  r_state     <= HOLD;
                  r_out_valid <= 1'b1;
               end else begin
                  r_tap <= r_tap + TAP_W'(1);
               end
            end
            HOLD: begin
               if (out_ready) begin
                  r_state     <= IDLE;
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_busy      <= 1'b0;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   fir_mac_unit #(
      .WIDTH  (WIDTH),
      .NCOEFS (NCOEFS),
      .FRAC   (FRAC)
   ) u_mac (
      .clock      (clock),
      .nreset     (nreset),
      .i_load     (w_accept),
      .i_en       (r_state == ACCUM),
      .i_hold     (r_state == HOLD),
      .i_coef     (w_mac_coef),
      .i_sample   (w_mac_samp),
      .o_result   (w_result)
`ifdef FIR_SATURATE_EN
      ,
      .o_sat_flag (sat_flag)
`endif
   );

   assign coef_drop = r_coef_drop;
   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_chan  = r_chan;
   assign out_data  = w_result;
   assign busy      = r_busy;

endmodule

// File: doc/fir_mc_serial.md
Name: fir_mc_serial

Overview:
Multi-channel, time-multiplexed FIR filter that generalises the fixed Gaussian FIR: programmable coefficients, NCHAN independent delay lines and one shared multiply-accumulator per sample.
Each sample is accepted through a valid/ready handshake and produces one filtered output after NCOEFS MAC cycles.
Sits between sample sources and downstream processing in the filter datapath.

Parameters:
WIDTH, 32, signed sample/coefficient/output width
NCOEFS, 29, number of taps (>=2)
NCHAN, 2, number of independent channels (>=1)
FRAC, 8, fractional bits of coefficients (Q-format, >=1)

Ports:
clock  in  1  system clock
nreset  in  1  asynchronous active-low reset
coef_we  in  1  coefficient write strobe
coef_addr  in  $clog2(NCOEFS)  tap index
coef_data  in  WIDTH  signed coefficient, Q(FRAC)
coef_drop  out  1  one-cycle pulse: write ignored (busy or addr>=NCOEFS)
in_valid  in  1  sample valid
in_ready  out  1  block can accept a sample
in_chan  in  $clog2(NCHAN) (min 1)  channel of sample
in_data  in  WIDTH  signed sample
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_chan  out  $clog2(NCHAN) (min 1)  channel of result
out_data  out  WIDTH  signed filtered sample
busy  out  1  state != IDLE

Behaviour:
- Reset nreset, asynchronous, active-low; clock clock. Reset clears all coefficients, all delay lines and the accumulator; FSM to IDLE; out_valid=0, out_data=0, out_chan=0, coef_drop=0, in_ready=1 after reset release.
- FSM: IDLE -> ACCUM -> HOLD -> IDLE.
- IDLE: in_ready=1. Handshake on in_valid&in_ready: sample written to head of delay line in_chan (oldest discarded), channel latched, accumulator loaded with rounding constant 2^(FRAC-1), tap counter=0, go to ACCUM.
- ACCUM: in_ready=0; one tap per cycle, acc += c[k]*x[chan][n-k], k=0..NCOEFS-1; exactly NCOEFS cycles, then HOLD.
- HOLD: out_valid=1 with out_data/out_chan stable until out_ready; on out_valid&out_ready return to IDLE (out_valid low next cycle). No new sample accepted in the same cycle as the output handshake.
- Latency: sample accepted at cycle 0 -> out_valid first high at cycle NCOEFS+1; throughput 1 sample per NCOEFS+2 cycles with out_ready held high.
- Arithmetic: full-precision signed products (2*WIDTH), accumulator 2*WIDTH+$clog2(NCOEFS) bits, never overflows. Result = acc >>> FRAC (arithmetic), round-half-up via preloaded constant, then reduced to WIDTH bits (see Optional Feature).
- Delay lines: circular buffer per channel with per-channel head pointer wrapping at NCOEFS-1 -> 0; history is initially zero; channels fully isolated.
- in_chan >= NCHAN: handshake completes, sample discarded, no output produced, stays IDLE.
- Coefficient writes are applied only in IDLE with coef_addr<NCOEFS; otherwise dropped and coef_drop pulses. If coef_we and an input handshake occur in the same IDLE cycle, the write is applied first and the new coefficient is used for that sample.
- Reset mid-ACCUM or mid-HOLD: immediate abort, no output, all state cleared as above.

Optional Feature:
FIR_SATURATE_EN: when defined, the shifted result is clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1] and a sticky output sat_flag (1 bit, cleared only by reset) is set on any clamp. When undefined, the result is truncated to its low WIDTH bits (two's-complement wrap) and the sat_flag port does not exist.

Decomposition:
- Package fir_pkg: state enum (IDLE, ACCUM, HOLD); width helper functions (acc width, index widths with min 1); rounding-constant function.
- Sub-module fir_mac_unit: accumulator with clear/preload, multiply-accumulate, shift/round and wrap-or-saturate output stage. The FSM, coefficient RAM and delay lines stay in fir_mc_serial.

Test Plan:
- All coefficients 256 (1.0 in Q8), ch0 samples 0, then 100 x29, then 10 -> outputs 0,100,200..2900, then 2810,2720,...; each out_valid exactly NCOEFS+1 cycles after acceptance.
- Impulse 256 on ch1 with c[k]=k -> successive ch1 outputs 0,1,2..28 then 0; ch0 outputs are unaffected by interleaved ch1 traffic.
- out_ready low 50 cycles in HOLD -> out_valid and out_data stable, in_ready=0 throughout, no sample lost when released.
- coef_we during ACCUM, and with coef_addr=29 -> coef_drop pulses, later outputs use the old coefficients.
- WIDTH=16, c[k]=256, input 32767 -> with FIR_SATURATE_EN out_data=32767 and sat_flag=1; without it, the wrapped low 16 bits.
- nreset asserted mid-ACCUM -> out_valid never rises, busy=0, and the next impulse gives results as from cold reset.
